// File: rtl/kfps2kb_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered frame decoder feeding a scan-code FIFO.
// Optional odd-parity checking is compiled in with `define KFPS2KB_PARITY_CHECK_EN.
module kfps2kb_fifo #(
   parameter int OVER_TIME  = 1000,
   parameter int FILTER_LEN = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          device_clock,
   input  logic                          device_data,
   output logic                          irq,
   output logic [7:0]                    keycode,
   input  logic                          clear_keycode,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic                          frame_error
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int TIMER_W = $clog2(OVER_TIME + 1);
   localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic               clk_s1_reg, clk_s2_reg, dat_s1_reg, dat_s2_reg;
   logic               filt_clk_reg;
   logic [3:0]         filt_cnt_reg;
   logic               fall;
   logic               timeout;
   logic               frame_good;
   state_t             state_reg, state_next;
   logic [2:0]         bit_cnt_reg;
   logic [7:0]         shift_reg;
   logic [TIMER_W-1:0] timer_reg;
   logic               push_reg, push_next;
   logic [7:0]         push_data_reg, push_data_next;
   logic               frame_error_reg, frame_error_next;
`ifdef KFPS2KB_PARITY_CHECK_EN
   logic               parity_reg;
`endif

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               overflow_reg;
   logic               pop, full, wr_en, ovf_set;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_s1_reg <= 1'b1;
         clk_s2_reg <= 1'b1;
         dat_s1_reg <= 1'b1;
         dat_s2_reg <= 1'b1;
      end else begin
         clk_s1_reg <= device_clock;
         clk_s2_reg <= clk_s1_reg;
         dat_s1_reg <= device_data;
         dat_s2_reg <= dat_s1_reg;
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt_clk_reg <= 1'b1;
         filt_cnt_reg <= '0;
      end else if (clk_s2_reg != filt_clk_reg) begin
         if (filt_cnt_reg == FILT_MAX) begin
            filt_clk_reg <= clk_s2_reg;
            filt_cnt_reg <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + 4'd1;
         end
      end else begin
         filt_cnt_reg <= '0;
      end
   end

   assign fall    = filt_clk_reg & ~clk_s2_reg & (filt_cnt_reg == FILT_MAX);
   assign timeout = (state_reg != IDLE) && !fall && (timer_reg == TIMER_W'(OVER_TIME - 1));

`ifdef KFPS2KB_PARITY_CHECK_EN
   assign frame_good = dat_s2_reg & (^{shift_reg, parity_reg});
`else
   assign frame_good = dat_s2_reg;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         timer_reg       <= '0;
         push_reg        <= 1'b0;
         push_data_reg   <= '0;
         frame_error_reg <= 1'b0;
`ifdef KFPS2KB_PARITY_CHECK_EN
         parity_reg      <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         push_reg        <= push_next;
         push_data_reg   <= push_data_next;
         frame_error_reg <= frame_error_next;
         if (fall) begin
            case (state_reg)
               IDLE: bit_cnt_reg <= '0;
               DATA: begin
                  shift_reg   <= {dat_s2_reg, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
               end
`ifdef KFPS2KB_PARITY_CHECK_EN
               PARITY: parity_reg <= dat_s2_reg;
`endif
               default: ;
            endcase
         end
         if (state_reg == IDLE || state_next == IDLE || fall)
            timer_reg <= '0;
         else
            timer_reg <= timer_reg + 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (fall && !dat_s2_reg) state_next = DATA;
         DATA:    if (fall && bit_cnt_reg == 3'd7) state_next = PARITY;
         PARITY:  if (fall) state_next = STOP;
         STOP:    if (fall) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (timeout) state_next = IDLE;
   end

   always_comb begin
      push_next        = 1'b0;
      push_data_next   = shift_reg;
      frame_error_next = 1'b0;
      if (state_reg == IDLE && fall && dat_s2_reg)
         frame_error_next = 1'b1;
      if (state_reg == STOP && fall) begin
         push_next = 1'b1;
         if (!frame_good) begin
            push_data_next   = 8'hFF;
            frame_error_next = 1'b1;
         end
      end
      if (timeout) begin
         push_next        = 1'b1;
         push_data_next   = 8'hFF;
         frame_error_next = 1'b1;
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign pop     = clear_keycode && (count_reg != '0);
   assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
   assign wr_en   = push_reg && (!full || pop);
   assign ovf_set = push_reg && full && !pop;

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr_reg] <= push_data_reg;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (wr_en && !pop)
            count_reg <= count_reg + 1'b1;
         else if (pop && !wr_en)
            count_reg <= count_reg - 1'b1;
         if (ovf_set)
            overflow_reg <= 1'b1;
         else if (clear_overflow)
            overflow_reg <= 1'b0;
      end
   end

   assign irq         = (count_reg != '0);
   assign keycode     = (count_reg != '0) ? mem[rd_ptr_reg] : 8'h00;
   assign fifo_count  = count_reg;
   assign overflow    = overflow_reg;
   assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_kfps2kb_fifo.sv
// Directed bench for kfps2kb_fifo: drives PS/2 frames on the pins and checks FIFO outputs.
module tb_kfps2kb_fifo;

   localparam int HP = 20;
   localparam int OVER_TIME = 1000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       device_clock = 1'b1;
   logic       device_data = 1'b1;
   logic       irq;
   logic [7:0] keycode;
   logic       clear_keycode = 1'b0;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       clear_overflow = 1'b0;
   logic       frame_error;

   int n_checks = 0;
   int n_pass = 0;
   int fe_cnt = 0;
   int fe_base;

   kfps2kb_fifo #(.OVER_TIME(OVER_TIME), .FILTER_LEN(4), .FIFO_DEPTH(8)) dut (
      .clock(clock), .reset(reset), .device_clock(device_clock), .device_data(device_data),
      .irq(irq), .keycode(keycode), .clear_keycode(clear_keycode), .fifo_count(fifo_count),
      .overflow(overflow), .clear_overflow(clear_overflow), .frame_error(frame_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (frame_error === 1'b1) fe_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %s ok: %0h", tag, got);
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ps2_bit(input logic b, input logic glitch);
      @(negedge clock) device_data = b;
      if (glitch) begin
         repeat (HP/2) @(negedge clock);
         device_clock = 1'b0;
         repeat (2) @(negedge clock);
         device_clock = 1'b1;
         repeat (HP/2) @(negedge clock);
      end else begin
         repeat (HP) @(negedge clock);
      end
      device_clock = 1'b0;
      repeat (HP) @(negedge clock);
      device_clock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_bit);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch_bit == i);
      ps2_bit(par, 1'b0);
      ps2_bit(stop, 1'b0);
      @(negedge clock) device_data = 1'b1;
      repeat (HP) @(negedge clock);
      $display("frame sent %02h par=%0b stop=%0b", d, par, stop);
   endtask

   task automatic good_frame(input logic [7:0] d);
      send_frame(d, ~^d, 1'b1, -1);
   endtask

   task automatic pop_one();
      @(negedge clock) clear_keycode = 1'b1;
      @(negedge clock) clear_keycode = 1'b0;
   endtask

   initial begin
      logic [7:0] seq [3];
      seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = 8'h75;

      repeat (3) @(negedge clock);
      check("rst_irq", irq, 0);
      check("rst_keycode", keycode, 8'h00);
      check("rst_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_error", frame_error, 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // single frame then pop
      good_frame(8'h1C);
      check("t1_irq", irq, 1);
      check("t1_keycode", keycode, 8'h1C);
      check("t1_count", fifo_count, 1);
      check("t1_no_err", fe_cnt, 0);
      pop_one();
      check("t1_pop_irq", irq, 0);
      check("t1_pop_keycode", keycode, 8'h00);
      check("t1_pop_count", fifo_count, 0);

      // multi-byte sequence
      for (int i = 0; i < 3; i++) good_frame(seq[i]);
      check("t2_count", fifo_count, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_head%0d", i), keycode, seq[i]);
         pop_one();
      end
      check("t2_irq", irq, 0);
      pop_one();
      check("t2_empty_pop_count", fifo_count, 0);

      // overflow
      for (int i = 1; i <= 9; i++) good_frame(8'(i));
      check("t3_count", fifo_count, 8);
      check("t3_overflow", overflow, 1);
      check("t3_head", keycode, 8'h01);
      @(negedge clock) clear_overflow = 1'b1;
      @(negedge clock) clear_overflow = 1'b0;
      check("t3_ovf_clear", overflow, 0);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("t3_head%0d", i), keycode, 32'(i));
         pop_one();
      end
      check("t3_drained", fifo_count, 0);

      // bad parity and bad stop
      fe_base = fe_cnt;
      send_frame(8'h5A, ^8'h5A, 1'b1, -1);
`ifdef KFPS2KB_PARITY_CHECK_EN
      check("t4_par_keycode", keycode, 8'hFF);
      check("t4_par_err", fe_cnt - fe_base, 1);
`else
      check("t4_par_keycode", keycode, 8'h5A);
      check("t4_par_err", fe_cnt - fe_base, 0);
`endif
      pop_one();
      fe_base = fe_cnt;
      send_frame(8'h5A, ~^8'h5A, 1'b0, -1);
      check("t4_stop_keycode", keycode, 8'hFF);
      check("t4_stop_err", fe_cnt - fe_base, 1);
      pop_one();

      // timeout mid-frame
      fe_base = fe_cnt;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      repeat (OVER_TIME + 10) @(negedge clock);
      check("t5_keycode", keycode, 8'hFF);
      check("t5_count", fifo_count, 1);
      check("t5_err", fe_cnt - fe_base, 1);
      pop_one();
      good_frame(8'h33);
      check("t5_recover", keycode, 8'h33);
      pop_one();

      // clock glitch mid-frame
      fe_base = fe_cnt;
      send_frame(8'hA5, ~^8'hA5, 1'b1, 4);
      check("t6_keycode", keycode, 8'hA5);
      check("t6_count", fifo_count, 1);
      check("t6_no_err", fe_cnt - fe_base, 0);
      pop_one();

      // fall with data high while idle
      fe_base = fe_cnt;
      ps2_bit(1'b1, 1'b0);
      repeat (HP) @(negedge clock);
      check("idle_err", fe_cnt - fe_base, 1);
      check("idle_count", fifo_count, 0);

      // reset mid-frame
      fe_base = fe_cnt;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b0, 1'b0);
      @(negedge clock) reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (HP) @(negedge clock);
      check("rstmid_count", fifo_count, 0);
      check("rstmid_err", fe_cnt - fe_base, 0);
      good_frame(8'h42);
      check("rstmid_recover", keycode, 8'h42);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kfps2kb_fifo.md
Name: kfps2kb_fifo

Overview:
Next-generation PS/2 keyboard receiver. Decodes 11-bit PS/2 device frames with a glitch filter, an inactivity timeout and frame checking. Queues received scan codes in a parametrised FIFO so that multi-byte sequences (E0/F0 prefixes) are not lost between CPU reads. Sits between the PS/2 pins and the interrupt/port logic of the host system.

Parameters:
OVER_TIME, 1000, clock cycles without a filtered device_clock falling edge mid-frame before the frame is aborted.
FILTER_LEN, 4, consecutive equal samples needed before the filtered device_clock changes (range 1..15).
FIFO_DEPTH, 8, scan-code FIFO entries (power of 2, >=2).

Ports:
clock  in  1  system clock; all logic is on the posedge.
reset  in  1  reset.
device_clock  in  1  PS/2 clock pin, asynchronous.
device_data  in  1  PS/2 data pin, asynchronous.
irq  out  1  high while the FIFO is non-empty.
keycode  out  8  FIFO head byte; 0x00 when empty.
clear_keycode  in  1  pop strobe, one pop per high cycle.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
overflow  out  1  sticky: a byte was dropped because the FIFO was full.
clear_overflow  in  1  clears overflow.
frame_error  out  1  one-cycle pulse per bad or aborted frame.

Behaviour:
- Reset: reset, asynchronous, active-high. Reset state:
  - irq=0, keycode=0x00, fifo_count=0, overflow=0, frame_error=0.
  - FIFO empty, FSM in IDLE, timeout counter 0.
  - Sync flops and filtered clock preset to 1 (idle-high bus).
- Input conditioning:
  - Two-flop synchroniser on each pin.
  - Filtered clock changes only after FILTER_LEN consecutive synchronised samples differ from its current value.
  - A "fall" is a 1->0 change of the filtered clock.
  - Data is sampled from the synchronised data flop on the fall cycle.
- FSM states and transitions:
  - IDLE:
    - fall with data=0 -> DATA, bit count=0.
    - fall with data=1 -> stay in IDLE, frame_error pulse, nothing pushed.
  - DATA: each fall shifts data into bit 7 of shift[7:0], LSB first. After the 8th fall -> PARITY.
  - PARITY: fall latches the parity bit -> STOP.
  - STOP: fall checks the stop bit (must be 1) and parity (if enabled).
    - Frame good -> push shift[7:0].
    - Frame bad -> push 0xFF and pulse frame_error.
    - Either case -> IDLE.
- Timeout:
  - In DATA, PARITY or STOP the counter increments every cycle and clears on each fall.
  - Counter reaching OVER_TIME -> push 0xFF, frame_error pulse, -> IDLE, counter cleared.
  - In IDLE the counter is held at 0.
- FIFO:
  - Circular buffer with pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - Push: write at the cycle after the terminating fall or timeout. irq, keycode and fifo_count reflect the push on the following cycle.
  - Pop: clear_keycode with count>0 advances the read pointer. keycode shows the next entry (or 0x00) the following cycle.
  - Pop when empty: ignored.
  - Push when full without a pop: byte dropped, overflow<=1, count unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. This includes the full case, where no overflow is raised.
  - clear_overflow coinciding with a new overflow event: overflow remains 1.
- Reset mid-frame: the frame is discarded with no push and no error pulse.

Optional Feature:
KFPS2KB_PARITY_CHECK_EN
- Defined: odd parity over data plus parity bit is required. A mismatch pushes 0xFF and pulses frame_error.
- Undefined: the parity bit is sampled and ignored. Only the start bit, stop bit and timeout are checked.

Test Plan:
1. Frame 0x1C with good parity and stop=1 -> irq=1, keycode=0x1C, fifo_count=1. Then one clear_keycode pulse -> irq=0, keycode=0x00, count=0.
2. Frames 0xE0, 0xF0, 0x75 with no pops -> count=3. Three pops return 0xE0, 0xF0, 0x75 in order, then irq=0.
3. FIFO_DEPTH=8, nine frames with no pops -> count=8, overflow=1, head 0x01..0x08 with the ninth byte dropped. Then clear_overflow -> overflow=0.
4. Frame 0x5A with wrong parity:
   - With macro: 0xFF pushed, frame_error pulse.
   - Without macro: 0x5A pushed, no pulse.
   - Stop=0: 0xFF pushed in both builds.
5. Four data bits, then clock held high for OVER_TIME+10 cycles -> 0xFF pushed, frame_error pulse. A following good frame 0x33 is received as 0x33.
6. FILTER_LEN=4, 2-cycle low glitch on device_clock mid-frame -> no bit sampled. The frame still decodes as sent, e.g. 0xA5.
